// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: accepts one 128-bit state, transforms
// COLS_PER_CYCLE columns per clock, and holds the result until it is taken.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] st_q, st_d;
  logic [127:0] res_q, res_d;
  logic [127:0] st_calc;
  logic [1:0]   col_idx;
  logic [2:0]   col_sum;
  logic         last_col;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // 0E*a0 ^ 0B*a1 ^ 0D*a2 ^ 09*a3, built from shared xtime chains.
  function automatic logic [7:0] inv_byte(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] a0_2, a0_4, a0_8, a1_2, a1_4, a1_8;
    logic [7:0] a2_2, a2_4, a2_8, a3_2, a3_4, a3_8;
    a0_2 = xtime(a0); a0_4 = xtime(a0_2); a0_8 = xtime(a0_4);
    a1_2 = xtime(a1); a1_4 = xtime(a1_2); a1_8 = xtime(a1_4);
    a2_2 = xtime(a2); a2_4 = xtime(a2_2); a2_8 = xtime(a2_4);
    a3_2 = xtime(a3); a3_4 = xtime(a3_2); a3_8 = xtime(a3_4);
    return (a0_8 ^ a0_4 ^ a0_2) ^ (a1_8 ^ a1_2 ^ a1) ^
           (a2_8 ^ a2_4 ^ a2)   ^ (a3_8 ^ a3);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {inv_byte(a0, a1, a2, a3), inv_byte(a1, a2, a3, a0),
            inv_byte(a2, a3, a0, a1), inv_byte(a3, a0, a1, a2)};
  endfunction

  // Column c lives at bits [(3-c)*32 +: 32]; only the columns due this edge change.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    st_calc = st_q;
    col_idx = col_q;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      col_idx = col_q + 2'(j);
      st_calc[(3 - col_idx) * 32 +: 32] = inv_col(st_q[(3 - col_idx) * 32 +: 32]);
    end
  end

  assign col_sum  = {1'b0, col_q} + STEP;
  assign last_col = col_sum[2];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (last_col)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state alone.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == CALC);
    out_valid = (state_q == DONE);
  end

  // Datapath next values; the counter holds at the last column rather than wrapping.
  always_comb begin
    st_d  = st_q;
    col_d = col_q;
    res_d = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d  = data_in;
          col_d = 2'd0;
        end
      end
      CALC: begin
        st_d = st_calc;
        if (last_col) res_d = st_calc;
        else          col_d = col_sum[1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= 2'd0;
      st_q  <= '0;
      res_q <= '0;
    end else begin
      col_q <= col_d;
      st_q  <= st_d;
      res_q <= res_d;
    end
  end

  assign data_out = res_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench: three instances (1, 2, 4 columns per cycle) checked
// against a GF(2^8) matrix model with directed vectors and random traffic.
module tb_inv_mix_columns_seq;

  logic         clk;
  logic         rst_n     [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] data_in   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] data_out  [3];
  logic         busy      [3];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .data_in   (data_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .data_out  (data_out[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Generic shift-and-add multiply in GF(2^8) mod 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // out_i = XOR_j coef[j] * a_((i+j) mod 4), for every column.
  function automatic logic [127:0] mix(input logic [127:0] s, input logic [7:0] k0,
                                       input logic [7:0] k1, input logic [7:0] k2,
                                       input logic [7:0] k3);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   b;
    logic [127:0] o;
    coef = '{k0, k1, k2, k3};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127 - 8 * (4 * c + r) -: 8];
      for (int i = 0; i < 4; i++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b ^= gmul(coef[j], a[(i + j) % 4]);
        o[127 - 8 * (4 * c + i) -: 8] = b;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] s);
    return mix(s, 8'h0E, 8'h0B, 8'h0D, 8'h09);
  endfunction

  function automatic logic [127:0] fwd_model(input logic [127:0] s);
    return mix(s, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_reset(input int k);
    rst_n[k] = 1'b0;
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[k] = 1'b1;
    @(negedge clk);
    check("reset_in_ready",  128'(in_ready[k]),  128'd1);
    check("reset_out_valid", 128'(out_valid[k]), 128'd0);
    check("reset_busy",      128'(busy[k]),      128'd0);
    check("reset_data_out",  data_out[k],        128'd0);
  endtask

  // One block; hold = cycles of out_ready=0 (with ignored in_valid pulses) after out_valid.
  task automatic run_block(input int k, input logic [127:0] din, input logic [127:0] exp,
                           input int hold);
    int lat;
    logic [127:0] held;
    check("pre_in_ready", 128'(in_ready[k]), 128'd1);
    out_ready[k] = 1'b0;
    in_valid[k] = 1'b1;
    data_in[k] = din;
    @(negedge clk);
    in_valid[k] = 1'b0;
    data_in[k] = rand128();
    check("calc_busy", 128'(busy[k]), 128'd1);
    check("calc_in_ready", 128'(in_ready[k]), 128'd0);
    lat = 0;
    while (!out_valid[k] && lat < 20) begin
      in_valid[k] = 1'($urandom_range(0, 1));
      data_in[k] = rand128();
      @(negedge clk);
      lat++;
    end
    in_valid[k] = 1'b0;
    check("latency", 128'(lat), 128'(4 >> k));
    check("result", data_out[k], exp);
    check("done_busy", 128'(busy[k]), 128'd0);
    held = data_out[k];
    repeat (hold) begin
      in_valid[k] = 1'($urandom_range(0, 1));
      data_in[k] = rand128();
      @(negedge clk);
      check("hold_data", data_out[k], held);
      check("hold_valid", 128'(out_valid[k]), 128'd1);
      check("hold_in_ready", 128'(in_ready[k]), 128'd0);
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    check("release_valid", 128'(out_valid[k]), 128'd0);
    check("release_in_ready", 128'(in_ready[k]), 128'd1);
    check("idle_keeps_data", data_out[k], held);
  endtask

  // Reset after two columns are done (immediately in CALC for the 4-column build).
  task automatic reset_mid(input int k);
    logic [127:0] din;
    in_valid[k] = 1'b1;
    data_in[k] = rand128();
    @(negedge clk);
    in_valid[k] = 1'b0;
    repeat ((k == 2) ? 0 : (2 >> k)) @(negedge clk);
    check("mid_busy", 128'(busy[k]), 128'd1);
    rst_n[k] = 1'b0;
    in_valid[k] = 1'b1;
    out_ready[k] = 1'b1;
    @(negedge clk);
    rst_n[k] = 1'b1;
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b0;
    check("rst_out_valid", 128'(out_valid[k]), 128'd0);
    check("rst_data_out", data_out[k], 128'd0);
    check("rst_in_ready", 128'(in_ready[k]), 128'd1);
    check("rst_busy", 128'(busy[k]), 128'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_stays_idle", 128'(out_valid[k]), 128'd0);
    end
    din = rand128();
    run_block(k, din, inv_model(din), 0);
  endtask

  task automatic back_to_back(input int k);
    logic [127:0] blk [3];
    logic [127:0] got [$];
    int t_out [$];
    int sent, cyc;
    for (int i = 0; i < 3; i++) blk[i] = rand128();
    out_ready[k] = 1'b1;
    in_valid[k] = 1'b1;
    data_in[k] = blk[0];
    sent = 1;
    cyc = 0;
    while (got.size() < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid[k]) begin
        got.push_back(data_out[k]);
        t_out.push_back(cyc);
      end
      if (in_ready[k]) begin
        if (sent < 3) begin
          data_in[k] = blk[sent];
          sent++;
        end else begin
          in_valid[k] = 1'b0;
        end
      end
    end
    in_valid[k] = 1'b0;
    @(negedge clk);
    out_ready[k] = 1'b0;
    check("b2b_count", 128'(got.size()), 128'd3);
    for (int i = 0; i < got.size() && i < 3; i++) begin
      check("b2b_result", got[i], inv_model(blk[i]));
      if (i > 0) check("b2b_spacing", 128'(t_out[i] - t_out[i-1]), 128'((4 >> k) + 2));
    end
    check("b2b_idle", 128'(in_ready[k]), 128'd1);
  endtask

  task automatic rand_test(input int k, input int n);
    logic [127:0] q [$];
    logic [127:0] src, din;
    logic nxt_or;
    int acc, cyc;
    acc = 0;
    cyc = 0;
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b0;
    while ((acc < n || q.size() > 0) && cyc < n * 40) begin
      @(negedge clk);
      cyc++;
      nxt_or = ($urandom_range(0, 3) != 0);
      if (out_valid[k] && nxt_or) begin
        if (q.size() == 0) begin
          check("rand_spurious_output", 128'd1, 128'd0);
        end else begin
          src = q.pop_front();
          check("rand_inv", data_out[k], inv_model(src));
          check("rand_fwd", fwd_model(data_out[k]), src);
        end
      end
      out_ready[k] = nxt_or;
      din = rand128();
      data_in[k] = din;
      in_valid[k] = (acc < n) && ($urandom_range(0, 2) != 0);
      if (in_ready[k] && in_valid[k]) begin
        q.push_back(din);
        acc++;
      end
    end
    in_valid[k] = 1'b0;
    check("rand_accepted", 128'(acc), 128'(n));
    check("rand_drained", 128'(q.size()), 128'd0);
    out_ready[k] = 1'b1;
    repeat (2) @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      data_in[k] = '0;
    end
    for (int k = 0; k < 3; k++) begin
      do_reset(k);
      run_block(k, {32'h046681E5, {3{32'h01010101}}},
                   {32'hD4BF5D30, {3{32'h01010101}}}, 0);
      run_block(k, 128'h8E4DA1BC_9FDC589D_C6C6C6C6_01010101,
                   128'hDB135345_F20A225C_C6C6C6C6_01010101, 10);
      reset_mid(k);
      back_to_back(k);
      rand_test(k, (k == 0) ? 1000 : 300);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
